dmem_arbiter: RTL

//  Shares the single-port, registered-read data memory between NUM_REQ requesters
//  (port 0 = core load/store path, port 1 = debug/DMA loader).

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_pick.sv | 44 ++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The request struct uses the package data width; the arbiter top defaults to the same width.
package dmem_arb_pkg;

    localparam int DMEM_DW     = 32;
    localparam int ARB_MAX_REQ = 16;
    localparam int ARB_IDX_W   = 4;

    typedef enum logic {IDLE, RESP} arb_state_e;

    typedef struct packed {
        logic               we;
        logic [DMEM_DW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } mem_req_t;

    function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++)
            if (oh[i]) idx = idx | ARB_IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational winner select: valid vector (+ pointer) -> one-hot grant.
// DMEM_ARB_RR_EN selects round-robin from ptr; otherwise fixed priority, lowest index wins.
module arb_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid,
`ifdef DMEM_ARB_RR_EN
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
    output logic [NUM_REQ-1:0]         grant
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        logic found;
        int   j;
        grant = '0;
        found = 1'b0;
        j     = 0;
        // Walk from ptr and wrap past the top port back to 0
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && valid[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one registered-read data memory between NUM_REQ ports, one transaction per two cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DW,
    parameter int NUM_REQ    = 2,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          mem_wen,
    output logic                          mem_ren,
    output logic [DATA_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e            state, state_nxt;
    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         gidx_c, gidx_q;
    mem_req_t              sel;
    logic                  hs, in_range;
    logic                  pend_rd, pend_err;
    logic [DATA_WIDTH-1:0] rdata_cur, rdata_hold;
    logic                  err_hold;

`ifdef DMEM_ARB_RR_EN
    logic [PW-1:0] ptr;
    arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (.valid(req_valid), .ptr(ptr), .grant(grant));
`else
    arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (.valid(req_valid), .grant(grant));
`endif

    assign gidx_c = PW'(onehot2idx(ARB_MAX_REQ'(grant)));

    always_comb begin
        sel.we    = req_we[gidx_c];
        sel.addr  = req_addr[int'(gidx_c)*DATA_WIDTH +: DATA_WIDTH];
        sel.wdata = req_wdata[int'(gidx_c)*DATA_WIDTH +: DATA_WIDTH];
    end

    // A handshake is only possible in IDLE; reset masks every grant
    assign hs        = (state == IDLE) && !rst && (|req_valid);
    assign req_ready = hs ? grant : '0;
    assign in_range  = sel.addr < DATA_WIDTH'(MEM_DEPTH);

    assign mem_wen   = hs &  sel.we & in_range;
    assign mem_ren   = hs & ~sel.we & in_range;
    assign mem_addr  = hs ? sel.addr  : '0;
    assign mem_wdata = hs ? sel.wdata : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gidx_q     <= '0;
            pend_rd    <= 1'b0;
            pend_err   <= 1'b0;
            rdata_hold <= '0;
            err_hold   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            ptr        <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (hs) begin
                gidx_q   <= gidx_c;
                pend_rd  <= ~sel.we & in_range;
                pend_err <= ~in_range;
`ifdef DMEM_ARB_RR_EN
                ptr      <= (int'(gidx_c) == NUM_REQ-1) ? '0 : gidx_c + 1'b1;
`endif
            end
            if (state == RESP) begin
                rdata_hold <= rdata_cur;
                err_hold   <= pend_err;
            end
        end
    end

    // Response data comes straight off the memory in RESP, then holds
    assign rdata_cur = pend_rd ? mem_rdata : '0;
    assign rsp_rdata = (state == RESP) ? rdata_cur : rdata_hold;
    assign rsp_err   = (state == RESP) ? pend_err  : err_hold;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = (state == RESP) && (gidx_q == PW'(i));
    end

endmodule
